johnson_phase_decoder: RTL
==========================

// Module: johnson_phase_decoder
// PURPOSE
//  Sits directly downstream of the 4-bit Johnson counter and consumes its {q3,q2,q1,q0} output.
//  Registers each code, decodes it into a binary phase index and a one-hot phase vector, and checks it.
//  Flags illegal codes and wrong successors, runs a lock FSM, and keeps saturating error and wrapping revolution counts.
// PARAMETERS
//  WIDTH       4   Johnson register width; 2*WIDTH legal phases
//  LOCK_COUNT  4   consecutive good transitions needed to enter LOCKED (>=1)
//  ERR_W       8   error counter width, saturating
//  REV_W       16  revolution counter width, wrapping
// PORTS
//  clk         in   1            rising-edge clock, same as counter
//  rst         in   1            synchronous, active-high reset
//  code_in     in   WIDTH        Johnson code, MSB = first stage (q3)
//  in_valid    in   1            code_in is sampled this cycle
//  err_clr     in   1            synchronous clear of err_count
//  phase_idx   out  clog2(2W)    decoded phase index
//  phase_oh    out  2*WIDTH      one-hot phase; all-zero when not out_valid
//  out_valid   out  1            phase outputs hold a legal decoded code
//  illegal     out  1            one-cycle pulse: sampled code is not a Johnson code
//  seq_err     out  1            one-cycle pulse: legal code but not the successor of the previous one
//  locked      out  1            FSM is in LOCKED
//  err_count   out  ERR_W        saturating count of illegal|seq_err events
//  rev_count   out  REV_W        count of legal wraps from phase 2W-1 to phase 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM = UNLOCKED; history invalid. rst has priority over every other input.
//  Stage 1 (edge N): if in_valid, code_r <= code_in and hist_v <= 1; otherwise hist_v <= 0, which breaks the sequence.
//  Stage 2 (edge N+1): decode code_r and update all outputs. Latency from code_in to outputs is 2 clocks.
//  Phase map (W=4): 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
//   - Phases 0..W: k leading ones from the MSB, phase = k.
//   - Phases W+1..2W-1: trailing ones only, phase = 2W - (number of ones).
//   - Any other pattern is illegal.
//  Illegal code: illegal=1, out_valid=0, phase_oh=0; phase_idx holds its last value.
//  Successor check: applies only when the previous stage-1 sample was also valid and legal.
//   - Required next phase = (prev+1) mod 2W; 7 -> 0 is legal.
//   - Any other legal phase, including a repeat of the same phase: seq_err=1.
//   - illegal and seq_err are never high in the same cycle; illegal wins.
//  First legal sample after reset, after an in_valid gap, or after an illegal code: not checked, no seq_err.
//  rev_count increments on a checked, correct transition from 2W-1 to 0; wraps to 0 at its maximum.
//  err_count increments by 1 when (illegal|seq_err) and holds at 2^ERR_W-1.
//   - err_clr forces 0 and wins over a same-cycle increment.
//  FSM states:
//   - UNLOCKED -> LOCKING on the first legal code; good_cnt = 0.
//   - LOCKING: each correct transition does good_cnt++.
//       * Reaching LOCK_COUNT: -> LOCKED.
//       * illegal or seq_err: -> UNLOCKED.
//       * in_valid gap: stay in LOCKING, good_cnt = 0.
//   - LOCKED: illegal or seq_err -> UNLOCKED, and locked drops in the same cycle the error pulse is high.
//       * An in_valid gap alone keeps LOCKED.
//  Mid-operation rst: the next sample is treated as a first sample, so no seq_err.
// TESTING
//  1. rst 3 cycles, then in_valid=1 with a free-running counter from 0000:
//     - phase_idx 0,1,..,7,0 with 2-cycle latency.
//     - locked rises after the 4th correct transition.
//     - rev_count=1 after the first 0001 -> 0000.
//  2. Inject 1010 once while LOCKED:
//     - illegal pulses one cycle; out_valid=0, phase_oh=0.
//     - locked=0 and err_count=1.
//     - The next legal code gives no seq_err.
//  3. Skip a phase (1100 -> 1111):
//     - seq_err=1 and locked drops.
//     - Re-lock after 4 good transitions.
//  4. Drop in_valid for 2 cycles mid-sequence and resume at any legal code:
//     - No seq_err; locked stays 1.
//  5. ERR_W=2 with 5 illegal codes:
//     - err_count saturates at 3.
//     - err_clr during a 6th error gives err_count=0.
//  6. Assert rst while LOCKED at phase 5:
//     - All outputs 0 next cycle.
//     - A following 0011 gives no seq_err and FSM = LOCKING.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder: registers the counter output, decodes phase index and one-hot,
// checks legality and succession, tracks lock state, error and revolution counts.
module johnson_phase_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    parameter int REV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          in_valid,
    input  logic                          err_clr,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic [2*WIDTH-1:0]            phase_oh,
    output logic                          out_valid,
    output logic                          illegal,
    output logic                          seq_err,
    output logic                          locked,
    output logic [ERR_W-1:0]              err_count,
    output logic [REV_W-1:0]              rev_count
);

    localparam int NPH = 2 * WIDTH;
    localparam int PW  = $clog2(NPH);
    localparam int GW  = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED
    } state_t;

    // Phase k <= WIDTH has k leading ones; later phases have 2*WIDTH-k trailing ones.
    function automatic logic [WIDTH-1:0] johnson_code(input int unsigned k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) johnson_code = ~(ones >> k);
        else            johnson_code = ~(ones << (NPH - k));
    endfunction

    logic [WIDTH-1:0] code_r_q, code_r_d;
    logic             hist_v_q, hist_v_d;
    logic             prev_v_q, prev_v_d;
    logic [PW-1:0]    prev_phase_q, prev_phase_d;
    logic [PW-1:0]    phase_idx_q, phase_idx_d;
    logic [NPH-1:0]   phase_oh_q, phase_oh_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    state_t           state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;

    logic             legal;
    logic [PW-1:0]    ph;
    logic [PW-1:0]    next_ph;
    logic             correct;

    always_comb begin
        legal = 1'b0;
        ph    = '0;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (code_r_q == johnson_code(k)) begin
                legal = 1'b1;
                ph    = k[PW-1:0];
            end
        end
        next_ph = (prev_phase_q == PW'(NPH - 1)) ? '0 : prev_phase_q + 1'b1;
    end

    always_comb begin
        code_r_d     = in_valid ? code_in : code_r_q;
        hist_v_d     = in_valid;
        prev_v_d     = 1'b0;
        prev_phase_d = prev_phase_q;
        phase_idx_d  = phase_idx_q;
        phase_oh_d   = '0;
        out_valid_d  = 1'b0;
        illegal_d    = 1'b0;
        seq_err_d    = 1'b0;
        correct      = 1'b0;
        rev_count_d  = rev_count_q;
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_count_d  = err_count_q;

        if (hist_v_q) begin
            if (!legal) begin
                illegal_d = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                phase_idx_d  = ph;
                phase_oh_d   = NPH'(1) << ph;
                prev_v_d     = 1'b1;
                prev_phase_d = ph;
                if (prev_v_q) begin
                    if (ph == next_ph) correct   = 1'b1;
                    else               seq_err_d = 1'b1;
                end
                if (correct && prev_phase_q == PW'(NPH - 1))
                    rev_count_d = rev_count_q + 1'b1;
            end
        end

        unique case (state_q)
            UNLOCKED: begin
                if (hist_v_q && legal) begin
                    state_d    = LOCKING;
                    good_cnt_d = '0;
                end
            end
            LOCKING: begin
                if (illegal_d || seq_err_d) begin
                    state_d = UNLOCKED;
                end else if (!hist_v_q) begin
                    good_cnt_d = '0;
                end else if (correct) begin
                    if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (illegal_d || seq_err_d) state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase

        if (err_clr)
            err_count_d = '0;
        else if ((illegal_d || seq_err_d) && err_count_q != '1)
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_r_q     <= '0;
            hist_v_q     <= 1'b0;
            prev_v_q     <= 1'b0;
            prev_phase_q <= '0;
            phase_idx_q  <= '0;
            phase_oh_q   <= '0;
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            state_q      <= UNLOCKED;
            good_cnt_q   <= '0;
            err_count_q  <= '0;
            rev_count_q  <= '0;
        end else begin
            code_r_q     <= code_r_d;
            hist_v_q     <= hist_v_d;
            prev_v_q     <= prev_v_d;
            prev_phase_q <= prev_phase_d;
            phase_idx_q  <= phase_idx_d;
            phase_oh_q   <= phase_oh_d;
            out_valid_q  <= out_valid_d;
            illegal_q    <= illegal_d;
            seq_err_q    <= seq_err_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            err_count_q  <= err_count_d;
            rev_count_q  <= rev_count_d;
        end
    end

    assign phase_idx = phase_idx_q;
    assign phase_oh  = phase_oh_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);
    assign err_count = err_count_q;
    assign rev_count = rev_count_q;

endmodule
